instr_fetch_ctrl: RTL

//   Instruction fetch/decode controller; the reading end of the program memory port.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/instr_decoder.sv | 55 +++++
 rtl/instr_fetch_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, select encodings and FSM states for the fetch/decode controller
package cpu_pkg;

  // 5-bit opcodes held in the top bits of the instruction word
  localparam logic [4:0] HLT  = 5'b00000;
  localparam logic [4:0] STO  = 5'b00001;
  localparam logic [4:0] LD_  = 5'b00010;
  localparam logic [4:0] LDI  = 5'b00011;
  localparam logic [4:0] ADD  = 5'b00100;
  localparam logic [4:0] ADDI = 5'b00101;
  localparam logic [4:0] SUB  = 5'b00110;
  localparam logic [4:0] SUBI = 5'b00111;

  // Accumulator source select
  localparam logic [1:0] SELA_RAM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Control set produced by the decoder, before EXEC gating
  typedef struct packed {
    logic       wr_ram;
    logic       rd_ram;
    logic       wr_acc;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
  } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational opcode to strobe/select decode
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [4:0] i_opcode,
  output ctrl_t      o_ctrl,
  output logic       o_is_hlt
);

  // Map each opcode to its datapath controls; unlisted opcodes decode as NOP
  always_comb begin
    o_ctrl   = '0;
    o_is_hlt = 1'b0;
    case (i_opcode)
      HLT: o_is_hlt = 1'b1;
      STO: o_ctrl.wr_ram = 1'b1;
      LD_: begin
        o_ctrl.rd_ram = 1'b1;
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SELA_RAM;
      end
      LDI: begin
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SELA_IMM;
      end
      ADD: begin
        o_ctrl.rd_ram = 1'b1;
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SELA_ALU;
      end
      ADDI: begin
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SELA_ALU;
        o_ctrl.sel_b  = 1'b1;
      end
      SUB: begin
        o_ctrl.rd_ram = 1'b1;
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SELA_ALU;
        o_ctrl.op     = 1'b1;
      end
      SUBI: begin
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SELA_ALU;
        o_ctrl.sel_b  = 1'b1;
        o_ctrl.op     = 1'b1;
      end
      default: begin
        o_ctrl   = '0;
        o_is_hlt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - two-cycle fetch/exec controller; INSTR_COUNT_EN adds Instr_Cnt
module instr_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int addr_bus  = 11,
  parameter int data_size = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  output logic [addr_bus-1:0]  Prog_Addr,
  input  logic [data_size-1:0] Prog_Data,
  output logic [addr_bus-1:0]  Data_Addr,
  output logic [data_size-1:0] Imm,
  output logic                 Wr_Ram,
  output logic                 Rd_Ram,
  output logic                 Wr_Acc,
  output logic [1:0]           Sel_A,
  output logic                 Sel_B,
  output logic                 Op,
  output logic                 Halted
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0]          Instr_Cnt
`endif
);

  state_t               r_state;
  logic [addr_bus-1:0]  r_pc;
  logic [data_size-1:0] r_ir;
  ctrl_t                w_dec;
  logic                 w_is_hlt;
  logic                 w_exec;

  instr_decoder u_dec (
    .i_opcode (r_ir[data_size-1 -: 5]),
    .o_ctrl   (w_dec),
    .o_is_hlt (w_is_hlt)
  );

  // Sequencer: capture IR in FETCH, advance PC leaving EXEC, park in HALT
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          r_ir    <= Prog_Data;
          r_state <= EXEC;
        end
        EXEC: begin
          if (w_is_hlt) begin
            r_state <= HALT;
          end else begin
            r_pc    <= r_pc + 1'b1;
            r_state <= FETCH;
          end
        end
        HALT:    r_state <= HALT;
        default: r_state <= FETCH;
      endcase
    end
  end

  // Strobes follow the state register so an async reset drops them at once
  assign w_exec    = (r_state == EXEC);
  assign Wr_Ram    = w_exec & w_dec.wr_ram;
  assign Rd_Ram    = w_exec & w_dec.rd_ram;
  assign Wr_Acc    = w_exec & w_dec.wr_acc;
  assign Sel_A     = w_exec ? w_dec.sel_a : SELA_RAM;
  assign Sel_B     = w_exec & w_dec.sel_b;
  assign Op        = w_exec & w_dec.op;
  assign Halted    = (r_state == HALT);
  assign Prog_Addr = r_pc;
  assign Data_Addr = r_ir[addr_bus-1:0];
  assign Imm       = {{(data_size-addr_bus){r_ir[addr_bus-1]}}, r_ir[addr_bus-1:0]};

`ifdef INSTR_COUNT_EN
  logic [31:0] r_instr_cnt;

  // Count every executed non-HLT instruction, saturating at all ones
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_instr_cnt <= '0;
    end else if (w_exec && !w_is_hlt && (r_instr_cnt != 32'hFFFF_FFFF)) begin
      r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign Instr_Cnt = r_instr_cnt;
`endif

endmodule
